// File: rtl/boot_sequencer.sv
// Boot sequencer: loads the data image, streams instruction/register images plus barrier
// and start-PC packets to each core, releases the cores and watches their memory port.
module boot_sequencer #(
   parameter int unsigned NUM_CORES_P = 1,
   parameter int unsigned I_DEPTH_P   = 1024,
   parameter int unsigned D_DEPTH_P   = 1024,
   parameter int unsigned R_COUNT_P   = 64,
   parameter logic [31:0] BAR_MASK_P  = 32'h2,
   parameter logic [9:0]  BAR_ADDR_P  = 10'd24,
   parameter logic [31:0] START_PC_P  = 32'h0,
   parameter logic [2:0]  OP_NULL_P   = 3'd0,
   parameter logic [2:0]  OP_INSTR_P  = 3'd1,
   parameter logic [2:0]  OP_REG_P    = 3'd2,
   parameter logic [2:0]  OP_PC_P     = 3'd3,
   parameter logic [2:0]  OP_BAR_P    = 3'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   output logic [1:0]  img_sel_o,
   output logic [9:0]  img_addr_o,
   input  logic [39:0] img_data_i,
   output logic        mem_v_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   output logic        pkt_v_o,
   output logic [9:0]  pkt_id_o,
   output logic [2:0]  pkt_op_o,
   output logic [31:0] pkt_data_o,
   output logic [9:0]  pkt_addr_o,
   input  logic        pkt_ready_i,
   input  logic        mon_v_i,
   input  logic [31:0] mon_addr_i,
   input  logic [31:0] mon_data_i,
   output logic        busy_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic [31:0] result_o,
   output logic [31:0] last_code_o,
   output logic [7:0]  code_cnt_o,
   output logic [31:0] cycles_o
);

   localparam logic [9:0] D_LAST    = 10'(D_DEPTH_P - 1);
   localparam logic [9:0] I_LAST    = 10'(I_DEPTH_P - 1);
   localparam logic [9:0] R_LAST    = 10'(R_COUNT_P - 1);
   localparam logic [3:0] CORE_LAST = 4'(NUM_CORES_P - 1);

   typedef enum logic [3:0] {IDLE, DMEM, INSTR, REG, BAR, PC, RELEASE, RUN, PASS, FAIL} state_t;

   state_t      state_q, state_d;
   logic [9:0]  idx_q, idx_d;
   logic [3:0]  core_q, core_d;
   logic        send_q, send_d, first_q, first_d;
   logic [39:0] hold_q, hold_d, word;
   logic [31:0] cycles_q, cycles_d, result_q, result_d, last_code_q, last_code_d;
   logic [7:0]  code_cnt_q, code_cnt_d;
   logic [9:0]  core_id;
   logic        boot_item, item_rdy, restart;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         core_q      <= '0;
         send_q      <= 1'b0;
         first_q     <= 1'b0;
         hold_q      <= '0;
         cycles_q    <= '0;
         result_q    <= '0;
         last_code_q <= '0;
         code_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         core_q      <= core_d;
         send_q      <= send_d;
         first_q     <= first_d;
         hold_q      <= hold_d;
         cycles_q    <= cycles_d;
         result_q    <= result_d;
         last_code_q <= last_code_d;
         code_cnt_q  <= code_cnt_d;
      end
   end

   assign core_id = {6'd0, core_q} + 10'd1;
   // Image data is only valid on the first send cycle; later stall cycles replay the capture.
   assign word    = first_q ? img_data_i : hold_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      core_d      = core_q;
      send_d      = send_q;
      first_d     = 1'b0;
      hold_d      = word;
      cycles_d    = cycles_q;
      result_d    = result_q;
      last_code_d = last_code_q;
      code_cnt_d  = code_cnt_q;
      boot_item   = 1'b1;
      item_rdy    = pkt_ready_i;
      restart     = 1'b0;
      img_sel_o   = 2'd0;
      img_addr_o  = '0;
      mem_v_o     = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      pkt_v_o     = 1'b0;
      pkt_id_o    = '0;
      pkt_op_o    = '0;
      pkt_data_o  = '0;
      pkt_addr_o  = '0;
      case (state_q)
         IDLE: begin
            boot_item = 1'b0;
            restart   = start_i;
         end
         DMEM: begin
            item_rdy    = mem_ready_i;
            img_sel_o   = 2'd0;
            img_addr_o  = idx_q;
            mem_v_o     = send_q;
            mem_addr_o  = {20'd0, idx_q, 2'b00};
            mem_wdata_o = word[31:0];
            if (send_q && mem_ready_i) begin
               if (idx_q == D_LAST) begin
                  idx_d   = '0;
                  state_d = INSTR;
               end else idx_d = idx_q + 10'd1;
            end
         end
         INSTR: begin
            img_sel_o  = 2'd1;
            img_addr_o = idx_q;
            pkt_v_o    = send_q;
            pkt_id_o   = core_id;
            pkt_op_o   = OP_INSTR_P;
            pkt_data_o = {16'd0, word[15:0]};
            pkt_addr_o = idx_q;
            if (send_q && pkt_ready_i) begin
               if (idx_q == I_LAST) begin
                  idx_d   = '0;
                  state_d = REG;
               end else idx_d = idx_q + 10'd1;
            end
         end
         REG: begin
            img_sel_o  = 2'd2;
            img_addr_o = idx_q;
            pkt_v_o    = send_q;
            pkt_id_o   = core_id;
            pkt_op_o   = OP_REG_P;
            pkt_data_o = word[31:0];
            pkt_addr_o = {4'd0, word[37:32]};
            if (send_q && pkt_ready_i) begin
               if (idx_q == R_LAST) begin
                  idx_d   = '0;
                  state_d = BAR;
               end else idx_d = idx_q + 10'd1;
            end
         end
         BAR: begin
            pkt_v_o    = send_q;
            pkt_id_o   = core_id;
            pkt_op_o   = OP_BAR_P;
            pkt_data_o = BAR_MASK_P;
            pkt_addr_o = BAR_ADDR_P;
            if (send_q && pkt_ready_i) state_d = PC;
         end
         PC: begin
            pkt_v_o    = send_q;
            pkt_id_o   = core_id;
            pkt_op_o   = OP_PC_P;
            pkt_data_o = START_PC_P;
            if (send_q && pkt_ready_i) begin
               if (core_q == CORE_LAST) begin
                  core_d  = '0;
                  state_d = RELEASE;
               end else begin
                  core_d  = core_q + 4'd1;
                  state_d = INSTR;
               end
            end
         end
         RELEASE: begin
            pkt_v_o    = send_q;
            pkt_id_o   = core_id;
            pkt_op_o   = OP_NULL_P;
            pkt_data_o = 32'hFFFF_FFFE;
            pkt_addr_o = BAR_ADDR_P;
            if (send_q && pkt_ready_i) begin
               if (core_q == CORE_LAST) begin
                  core_d   = '0;
                  cycles_d = '0;
                  state_d  = RUN;
               end else core_d = core_q + 4'd1;
            end
         end
         RUN: begin
            boot_item = 1'b0;
            if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
            if (mon_v_i) begin
               case (mon_addr_i)
                  32'hDEAD_DEAD: begin
                     state_d  = FAIL;
                     result_d = mon_data_i;
                  end
                  32'h600D_BEEF: begin
                     state_d  = PASS;
                     result_d = mon_data_i;
                  end
                  32'hC0DE_C0DE, 32'hC0FF_EEEE: begin
                     last_code_d = mon_data_i;
                     if (code_cnt_q != 8'hFF) code_cnt_d = code_cnt_q + 8'd1;
                  end
                  default: ;
               endcase
            end
         end
         PASS, FAIL: begin
            boot_item = 1'b0;
            restart   = start_i;
         end
         default: begin
            boot_item = 1'b0;
            state_d   = IDLE;
         end
      endcase

      // Every boot item is a fetch cycle followed by a send phase held until ready.
      if (boot_item) begin
         if (!send_q) begin
            send_d  = 1'b1;
            first_d = 1'b1;
         end else if (item_rdy) send_d = 1'b0;
      end

      if (restart) begin
         state_d     = DMEM;
         idx_d       = '0;
         core_d      = '0;
         send_d      = 1'b0;
         cycles_d    = '0;
         result_d    = '0;
         last_code_d = '0;
         code_cnt_d  = '0;
      end
   end

   assign busy_o      = !(state_q inside {IDLE, PASS, FAIL});
   assign pass_o      = (state_q == PASS);
   assign fail_o      = (state_q == FAIL);
   assign result_o    = result_q;
   assign last_code_o = last_code_q;
   assign code_cnt_o  = code_cnt_q;
   assign cycles_o    = cycles_q;

endmodule
